seq_payload_capture: RTL and testbench
======================================

SEQ_PAYLOAD_CAPTURE -- requirements
Module: seq_payload_capture

Interface
REQ-001 The block SHALL have parameter PAYLOAD_W, default 8, giving the payload bits captured per detected sync.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, a power of two ≥2, giving the output buffer entries.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data, input, 1 bit: the serial bit stream, shared with the upstream sync detector.
REQ-006 The block SHALL have port seq_true, input, 1 bit: sync-detected strobe, high in the cycle the final sync bit is on data.
REQ-007 The block SHALL have port m_data, output, PAYLOAD_W bits: the captured payload at the buffer head.
REQ-008 The block SHALL have port m_valid, output, 1 bit: the buffer is non-empty.
REQ-009 The block SHALL have port m_ready, input, 1 bit: the consumer accepts m_data.
REQ-010 The block SHALL have port overflow, output, 1 bit: one-cycle pulse when a completed payload is dropped.
REQ-011 The block SHALL have port drop_cnt, output, 8 bits: saturating count of dropped payloads.

Function
REQ-012 The capture FSM SHALL have states IDLE and SHIFT, with a bit counter of width clog2(PAYLOAD_W)+1.
REQ-013 In IDLE, seq_true=1 at a clock edge SHALL move the FSM to SHIFT with the counter at 0, sampling no data bit at that edge.
REQ-014 In SHIFT, each edge SHALL shift data into the shift register MSB-first (first payload bit ends up in m_data[PAYLOAD_W-1]) and increment the counter.
REQ-015 The edge that samples payload bit PAYLOAD_W-1 SHALL write {shreg[PAYLOAD_W-2:0], data} to the buffer and return the FSM to IDLE.
REQ-016 seq_true asserted while in SHIFT SHALL be ignored, because payload bits may mimic the sync pattern.
REQ-017 seq_true in the same cycle as the completing edge SHALL NOT start a new capture; the FSM SHALL be in IDLE at the following edge.
REQ-018 m_valid SHALL rise the cycle after the completing edge when the buffer was empty, giving a write-to-valid latency of 1 cycle.
REQ-019 A transfer SHALL occur on any edge with m_valid=1 and m_ready=1; the head SHALL then advance.
REQ-020 m_data SHALL be held stable while m_valid=1 and m_ready=0.
REQ-021 A write SHALL be accepted if the buffer is not full, or if it is full and a transfer occurs on the same edge.
REQ-022 A write to a full buffer with no same-edge transfer SHALL discard the new payload, keep buffer contents unchanged, pulse overflow for one cycle, and increment drop_cnt, saturating at 255.
REQ-023 A simultaneous write and read on an empty buffer SHALL NOT occur, since m_valid=0; the write SHALL be stored.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH, with full/empty distinguished by an extra pointer MSB.

Reset
REQ-025 While rstn=0, the block SHALL hold: FSM IDLE, counter 0, shift register 0, buffer empty, m_valid 0, m_data 0, overflow 0, drop_cnt 0.
REQ-026 Reset asserted mid-capture SHALL discard the partial payload, with no write after deassertion.
REQ-027 Reset SHALL take effect asynchronously; release SHALL be sampled on the first clk edge after rstn rises.

Structure
REQ-028 A shared package/header SHALL hold the FSM state encodings (IDLE=1'b0, SHIFT=1'b1) and the default PAYLOAD_W and FIFO_DEPTH.
REQ-029 The buffer SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH; ports clk, rstn, wr_en, wr_data, full, rd_en, rd_data, empty), instantiated once.

Verification
REQ-030 The bench SHALL cover: seq_true pulse, then data bits 1,0,1,1,0,0,1,0 -> m_valid rises 1 cycle after the 8th bit, m_data=8'hB2.
REQ-031 The bench SHALL cover: seq_true pulses during payload bits 3 and 7 -> single capture only, no extra frames, FSM in IDLE after the 8th bit.
REQ-032 The bench SHALL cover: m_ready=0, 5 back-to-back frames 8'h01..8'h05 -> 4 stored, overflow pulses once, drop_cnt=1; then m_ready=1 -> outputs 01,02,03,04 in order.
REQ-033 The bench SHALL cover: full buffer with m_ready=1 on the completing edge of a 5th frame -> no drop, 5th frame delivered after the 4 stored ones.
REQ-034 The bench SHALL cover: rstn pulsed low after 4 payload bits -> m_valid stays 0; the next full frame 8'hA5 is captured correctly.
REQ-035 The bench SHALL cover: 300 dropped frames with m_ready=0 -> drop_cnt saturates at 255 and does not wrap.

Source files
------------

// File: rtl/seq_payload_capture_pkg.sv
// Shared types and defaults for the sync-triggered payload capture block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_payload_capture_pkg;

  // Capture FSM encoding; IDLE waits for a sync strobe, SHIFT collects payload bits.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } cap_state_t;

  localparam int DEF_PAYLOAD_W  = 8;
  localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/seq_payload_capture_if.sv
// Valid/ready channel that carries captured payloads to the consumer.
// Latency: n/a (wiring only).
// Backpressure: the consumer holds m_ready low and the producer keeps m_data stable.
interface seq_payload_capture_if
  import seq_payload_capture_pkg::*;
#(
  parameter int PAYLOAD_W = DEF_PAYLOAD_W
);

  logic [PAYLOAD_W-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/seq_payload_capture_fifo.sv
// Synchronous FIFO with registered pointers; the head entry is presented combinationally.
// Latency: a write is visible at rd_data/empty one cycle after the write edge.
// Backpressure: a write to a full FIFO is accepted only when a read happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so full and empty can be told apart.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_acc;
  logic             rd_acc;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_acc  = rd_en && !empty;
  // A full FIFO still takes a write if the head leaves on the same edge.
  assign wr_acc  = wr_en && (!full || rd_acc);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage and pointer update; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_acc) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/seq_payload_capture.sv
// Captures PAYLOAD_W serial bits after each sync strobe and queues them for a valid/ready consumer.
// Latency: payload valid one cycle after the edge that samples its last bit.
// Backpressure: buffer absorbs FIFO_DEPTH payloads; a payload completing into a full buffer is dropped and counted.
module seq_payload_capture
  import seq_payload_capture_pkg::*;
#(
  parameter int PAYLOAD_W  = DEF_PAYLOAD_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   data,
  input  logic                   seq_true,
  seq_payload_capture_if.master  m,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int CNT_W = $clog2(PAYLOAD_W) + 1;

  cap_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic [PAYLOAD_W-1:0] shreg;
  logic [PAYLOAD_W-1:0] sh_nxt;
  logic                 last_bit;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 rd_en;
  logic                 drop;

  assign sh_nxt   = {shreg[PAYLOAD_W-2:0], data};
  assign last_bit = (state == SHIFT) && (cnt == CNT_W'(PAYLOAD_W - 1));
  assign rd_en    = m.m_valid && m.m_ready;
  assign drop     = last_bit && fifo_full && !rd_en;

  // Capture FSM: sync strobes are only honoured in IDLE, since payload bits can mimic the sync pattern.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (seq_true) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          shreg <= sh_nxt;
          if (last_bit) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Drop reporting: one-cycle overflow pulse and a counter that sticks at its maximum.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      overflow <= drop;
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (PAYLOAD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (last_bit),
    .wr_data (sh_nxt),
    .full    (fifo_full),
    .rd_en   (rd_en),
    .rd_data (m.m_data),
    .empty   (fifo_empty)
  );

  assign m.m_valid = !fifo_empty;

endmodule

// File: tb/tb_seq_payload_capture.sv
// Directed bench for seq_payload_capture with a payload scoreboard.
// Latency: checks the one-cycle write-to-valid path.
// Backpressure: exercises full-buffer drops, same-edge read/write and drop counter saturation.
module tb_seq_payload_capture;
  import seq_payload_capture_pkg::*;

  logic       clk;
  logic       rstn;
  logic       data;
  logic       seq_true;
  logic       overflow;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  seq_payload_capture_if #(.PAYLOAD_W(8)) m_if ();

  seq_payload_capture #(
    .PAYLOAD_W  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .data     (data),
    .seq_true (seq_true),
    .m        (m_if),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_sync();
    seq_true = 1'b1;
    @(negedge clk);
    seq_true = 1'b0;
  endtask

  task automatic shift_bit(input logic b, input logic st);
    data     = b;
    seq_true = st;
    @(negedge clk);
    seq_true = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] p);
    start_sync();
    for (int i = 7; i >= 0; i--) begin
      shift_bit(p[i], 1'b0);
    end
    data = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    m_if.m_ready = 1'b1;
    while (exp_q.size() > 0) begin
      n = 0;
      while (!m_if.m_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!m_if.m_valid) begin
        check({tag, "_timeout"}, {31'b0, m_if.m_valid}, 32'd1);
        exp_q.delete();
        break;
      end
      check(tag, {24'b0, m_if.m_data}, {24'b0, exp_q.pop_front()});
      @(negedge clk);
    end
    check({tag, "_empty"}, {31'b0, m_if.m_valid}, 32'd0);
    m_if.m_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] p;
    rstn         = 1'b0;
    data         = 1'b0;
    seq_true     = 1'b0;
    m_if.m_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_valid", {31'b0, m_if.m_valid}, 32'd0);
    check("rst_data", {24'b0, m_if.m_data}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    check("rst_drop", {24'b0, drop_cnt}, 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    rstn = 1'b1;
    @(negedge clk);

    // Basic capture of 1,0,1,1,0,0,1,0 and its valid timing
    p = 8'hB2;
    start_sync();
    for (int i = 7; i >= 1; i--) shift_bit(p[i], 1'b0);
    check("b2_valid_before", {31'b0, m_if.m_valid}, 32'd0);
    shift_bit(p[0], 1'b0);
    data = 1'b0;
    check("b2_valid_after", {31'b0, m_if.m_valid}, 32'd1);
    check("b2_data", {24'b0, m_if.m_data}, 32'hB2);
    exp_q.push_back(8'hB2);
    drain("b2_out");

    // Sync strobes inside the payload (bits 3, 7 and the completing bit 8) are ignored
    p = 8'h3C;
    start_sync();
    for (int i = 1; i <= 8; i++) begin
      shift_bit(p[8-i], (i == 3 || i == 7 || i == 8));
    end
    data = 1'b0;
    check("mimic_state", 32'(dut.state), 32'(IDLE));
    check("mimic_valid", {31'b0, m_if.m_valid}, 32'd1);
    check("mimic_data", {24'b0, m_if.m_data}, 32'h3C);
    repeat (12) @(negedge clk);
    check("mimic_state_later", 32'(dut.state), 32'(IDLE));
    exp_q.push_back(8'h3C);
    drain("mimic_out");

    // Five frames into a stalled consumer: the fifth is dropped
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k));
      if (k <= 4) begin
        exp_q.push_back(8'(k));
        check("ovf_quiet", {31'b0, overflow}, 32'd0);
      end
    end
    check("ovf_pulse", {31'b0, overflow}, 32'd1);
    check("ovf_cnt", {24'b0, drop_cnt}, 32'd1);
    @(negedge clk);
    check("ovf_pulse_end", {31'b0, overflow}, 32'd0);
    drain("ovf_out");

    // Full buffer with a same-edge read: fifth frame accepted
    for (int k = 0; k < 4; k++) begin
      send_frame(8'h10 + 8'(k));
      exp_q.push_back(8'h10 + 8'(k));
    end
    exp_q.push_back(8'h14);
    p = 8'h14;
    start_sync();
    for (int i = 7; i >= 1; i--) shift_bit(p[i], 1'b0);
    check("same_edge_head", {24'b0, m_if.m_data}, {24'b0, exp_q.pop_front()});
    m_if.m_ready = 1'b1;
    shift_bit(p[0], 1'b0);
    m_if.m_ready = 1'b0;
    data = 1'b0;
    check("same_edge_ovf", {31'b0, overflow}, 32'd0);
    check("same_edge_cnt", {24'b0, drop_cnt}, 32'd1);
    drain("same_edge_out");

    // Reset in the middle of a capture discards the partial payload
    start_sync();
    shift_bit(1'b1, 1'b0);
    shift_bit(1'b0, 1'b0);
    shift_bit(1'b1, 1'b0);
    shift_bit(1'b1, 1'b0);
    rstn = 1'b0;
    #1;
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    check("mid_rst_cnt", {24'b0, drop_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    shift_bit(1'b0, 1'b0);
    shift_bit(1'b0, 1'b0);
    shift_bit(1'b1, 1'b0);
    shift_bit(1'b0, 1'b0);
    data = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_valid", {31'b0, m_if.m_valid}, 32'd0);
    send_frame(8'hA5);
    check("a5_valid", {31'b0, m_if.m_valid}, 32'd1);
    exp_q.push_back(8'hA5);
    drain("a5_out");

    // Drop counter saturation over 300 dropped frames
    for (int k = 0; k < 4; k++) begin
      send_frame(8'h60 + 8'(k));
      exp_q.push_back(8'h60 + 8'(k));
    end
    for (int k = 1; k <= 300; k++) begin
      send_frame(8'hFF);
      if (k == 255) check("sat_255", {24'b0, drop_cnt}, 32'd255);
    end
    check("sat_final", {24'b0, drop_cnt}, 32'd255);
    drain("sat_out");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
